// File: rtl/wide_add_seq.sv
// ============================================================================
// Module   : wide_add_seq
// Brief    : Two-pass 16-bit add sequencer feeding an external 8-bit ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wide_add_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a16,
    input  logic [15:0] b16,
    input  logic [3:0]  flags_in,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    input  logic [7:0]  alu_res,
    input  logic        alu_cout,
    input  logic        alu_hout,
    output logic        busy,
    output logic        done,
    output logic [15:0] res16,
    output logic [3:0]  flags_out,
    output logic        flags_we
);

    localparam logic [1:0] OP_ADD16  = 2'b00;
    localparam logic [1:0] OP_ADDSPE = 2'b01;
    localparam logic [1:0] OP_INC16  = 2'b10;
    localparam logic [1:0] OP_DEC16  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  flags_q;
    logic [7:0]  lo_byte;
    logic        lo_c;
    logic        lo_h;
    logic [15:0] b_eff;
    logic [3:0]  flags_nxt;

    // Effective second operand: INC/DEC are folded into a plain add.
    always_comb begin
        b_eff = b16;
        case (op)
            OP_ADD16:  b_eff = b16;
            OP_ADDSPE: b_eff = {{8{b16[7]}}, b16[7:0]};
            OP_INC16:  b_eff = 16'h0000;
            OP_DEC16:  b_eff = 16'hFFFF;
            default:   b_eff = b16;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_cin   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_LO;
                end
            end
            S_LO: begin
                alu_a     = a_q[7:0];
                alu_b     = b_q[7:0];
                alu_cin   = (op_q == OP_INC16);
                state_nxt = S_HI;
            end
            S_HI: begin
                alu_a     = a_q[15:8];
                alu_b     = b_q[15:8];
                alu_cin   = lo_c;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_LO;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Flag update evaluated during HI; the high-byte ALU carries act as hi_c/hi_h.
    always_comb begin
        flags_nxt = flags_q;
        case (op_q)
            OP_ADD16:  flags_nxt = {flags_q[3], 1'b0, alu_hout, alu_cout};
            OP_ADDSPE: flags_nxt = {1'b0, 1'b0, lo_h, lo_c};
            default:   flags_nxt = flags_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            op_q      <= 2'b00;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            flags_q   <= 4'h0;
            lo_byte   <= 8'h00;
            lo_c      <= 1'b0;
            lo_h      <= 1'b0;
            res16     <= 16'h0000;
            flags_out <= 4'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op;
                a_q     <= a16;
                b_q     <= b_eff;
                flags_q <= flags_in;
            end
            if (state == S_LO) begin
                lo_byte <= alu_res;
                lo_c    <= alu_cout;
                lo_h    <= alu_hout;
            end
            // Whole result commits at once so res16 never shows a half-updated value.
            if (state == S_HI) begin
                res16     <= {alu_res, lo_byte};
                flags_out <= flags_nxt;
            end
        end
    end

    assign busy     = (state == S_LO) || (state == S_HI);
    assign done     = (state == S_DONE);
    assign flags_we = (state == S_DONE) && !op_q[1];

endmodule

`default_nettype wire

// File: tb/tb_wide_add_seq.sv
// ============================================================================
// Module   : tb_wide_add_seq
// Brief    : Self-checking bench for wide_add_seq with a behavioural ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wide_add_seq;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [3:0]  flags_in;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [7:0]  alu_res;
    logic        alu_cout;
    logic        alu_hout;
    logic        busy;
    logic        done;
    logic [15:0] res16;
    logic [3:0]  flags_out;
    logic        flags_we;

    int checks   = 0;
    int failures = 0;

    wide_add_seq dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .a16(a16), .b16(b16),
        .flags_in(flags_in), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_hout(alu_hout),
        .busy(busy), .done(done), .res16(res16), .flags_out(flags_out),
        .flags_we(flags_we)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // 8-bit ALU the sequencer drives
    always_comb begin
        logic [8:0] s;
        logic [4:0] n;
        s        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        n        = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, alu_cin};
        alu_res  = s[7:0];
        alu_cout = s[8];
        alu_hout = n[4];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic straight from the operation definitions.
    task automatic model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, output logic [15:0] r, output logic [3:0] fl,
                         output logic we);
        int unsigned av, bv, cin, sum;
        av  = a;
        cin = 0;
        case (o)
            2'b00:   bv = b;
            2'b01:   bv = b[7] ? (32'hFF00 | b[7:0]) : b[7:0];
            2'b10: begin bv = 0; cin = 1; end
            default: bv = 32'hFFFF;
        endcase
        sum = av + bv + cin;
        r   = sum[15:0];
        we  = 1'b1;
        case (o)
            2'b00: fl = {f[3], 1'b0, 1'(((av & 32'hFFF) + (bv & 32'hFFF)) >> 12), 1'(sum >> 16)};
            2'b01: fl = {2'b00, 1'(((av & 32'hF) + (bv & 32'hF)) >> 4),
                         1'(((av & 32'hFF) + (bv & 32'hFF)) >> 8)};
            default: begin fl = f; we = 1'b0; end
        endcase
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance (LO).
    task automatic go(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] f);
        start = 1'b1; op = o; a16 = a; b16 = b; flags_in = f;
        @(negedge CLK);
        start = 1'b0;
        op = 2'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); flags_in = 4'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 6) begin
            @(negedge CLK);
            n++;
        end
        check({nm, " latency"}, 32'(n), 32'd2);
    endtask

    task automatic check_result(input string nm, input logic [15:0] er, input logic [3:0] ef,
                                input logic ew);
        check({nm, " res16"}, 32'(res16), 32'(er));
        check({nm, " flags_out"}, 32'(flags_out), 32'(ef));
        check({nm, " flags_we"}, 32'(flags_we), 32'(ew));
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
        logic [15:0] er;
        logic [3:0]  ef;
        logic        ew;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ndone;
        logic [15:0] er;
        logic [3:0]  ef;
        logic        ew;
        logic [1:0]  ro;
        logic [15:0] ra, rb;
        logic [3:0]  rf;

        vecs[0] = '{2'b00, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b1};
        vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 1'b1};
        vecs[2] = '{2'b01, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0011, 1'b1};
        vecs[3] = '{2'b01, 16'h0000, 16'h00FF, 4'b1100, 16'hFFFF, 4'b0000, 1'b1};
        vecs[4] = '{2'b11, 16'h0000, 16'h1234, 4'b0101, 16'hFFFF, 4'b0101, 1'b0};
        vecs[5] = '{2'b10, 16'h00FF, 16'hABCD, 4'b1010, 16'h0100, 4'b1010, 1'b0};

        RST = 1'b1; start = 1'b0; op = 2'b00; a16 = '0; b16 = '0; flags_in = '0;
        repeat (3) @(negedge CLK);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset flags_we", 32'(flags_we), 32'd0);
        check("reset res16", 32'(res16), 32'd0);
        check("reset flags_out", 32'(flags_out), 32'd0);
        check("reset alu", 32'({alu_a, alu_b, alu_cin}), 32'd0);
        start = 1'b1;
        @(negedge CLK);
        check("reset overrides start", 32'(busy), 32'd0);
        start = 1'b0;
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            go(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].f);
            wait_done($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i), vecs[i].er, vecs[i].ef, vecs[i].ew);
            @(negedge CLK);
        end

        // DEC16 then INC16 accepted in the DONE cycle
        go(2'b11, 16'h0000, 16'h0000, 4'b0000);
        wait_done("dec");
        check_result("dec", 16'hFFFF, 4'b0000, 1'b0);
        go(2'b10, 16'hFFFF, 16'h0000, 4'b0000);
        check("b2b res16 held", 32'(res16), 32'hFFFF);
        wait_done("b2b inc");
        check_result("b2b inc", 16'h0000, 4'b0000, 1'b0);
        @(negedge CLK);

        // Starts during LO and HI are ignored
        start = 1'b1; op = 2'b00; a16 = 16'h1234; b16 = 16'h1111; flags_in = 4'b0000;
        @(negedge CLK);
        check("lo alu_a", 32'(alu_a), 32'h34);
        check("lo alu_b", 32'(alu_b), 32'h11);
        check("lo busy", 32'(busy), 32'd1);
        op = 2'b01; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(negedge CLK);
        check("hi alu_a", 32'(alu_a), 32'h12);
        check("hi alu_b", 32'(alu_b), 32'h11);
        @(negedge CLK);
        start = 1'b0;
        check("ignore done", 32'(done), 32'd1);
        check_result("ignore", 16'h2345, 4'b0000, 1'b1);
        ndone = 0;
        repeat (5) begin
            @(negedge CLK);
            if (done) ndone++;
        end
        check("ignore extra dones", 32'(ndone), 32'd0);

        // Reset during HI aborts
        go(2'b00, 16'h0FFF, 16'h0001, 4'b1000);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort flags_we", 32'(flags_we), 32'd0);
        check("abort res16", 32'(res16), 32'd0);
        check("abort alu", 32'({alu_a, alu_b}), 32'd0);
        ndone = 0;
        repeat (4) begin
            @(negedge CLK);
            if (done || flags_we) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);

        // Randomized back-to-back and spaced operations against the model
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom); ra = 16'($urandom); rb = 16'($urandom); rf = 4'($urandom);
            if (i % 7 == 0) ra = 16'hFFFF;
            if (i % 5 == 0) rb = 16'h0001;
            model(ro, ra, rb, rf, er, ef, ew);
            go(ro, ra, rb, rf);
            wait_done($sformatf("rand%0d", i));
            check_result($sformatf("rand%0d op%0d", i, ro), er, ef, ew);
            if ($urandom_range(0, 1) == 0) @(negedge CLK);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
